inference_sequencer: RTL
========================

# inference_sequencer

Time-multiplexed controller and shared datapath for the two-layer binary-input classifier: one saturating MAC replaces the fully parallel layer-1/ReLU/layer-2/argmax network. It accepts a 1-bit pixel stream, fetches weights from an external synchronous ROM, and sequences layer 1, ReLU, layer 2 and argmax. It presents a 4-bit label through a valid/ready handshake, and sits between the pixel source and the result sink.

## Interface
- M1, 324, pixels per frame (layer-1 row length)
- N1, 10, hidden neurons
- N2, 10, output classes (≤16)
- WIDTH, 16, weight/activation width, two's complement
- FRAC, 8, fractional bits of layer-2 weights (Q7.8)
- AW, 12, weight ROM address width (must cover N1*M1+N2*N1)
- clk  in  1  clock, all logic on rising edge
- resetn  in  1  reset, asynchronous, active-low
- in_valid  in  1  pixel beat valid
- in_ready  out  1  high only in LOAD
- in_pixel  in  1  binary pixel
- in_last  in  1  source's end-of-frame marker
- w_addr  out  AW  ROM address; layer 1 at i*M1+j; layer 2 at N1*M1+k*N1+i
- w_data  in  WIDTH  ROM data, valid exactly 1 cycle after w_addr
- out_valid  out  1  label valid
- out_ready  in  1  sink accepts label
- out_label  out  4  argmax class index
- err_last  out  1  one-cycle pulse on frame-length mismatch

## Operation
- States: IDLE → LOAD → L1 → L2 → ARGMAX → DONE → IDLE.
- IDLE: one cycle; clears the pixel counter and accumulators.
- LOAD: each beat with in_valid&in_ready is written into pixel buffer[cnt]. The beat with cnt==M1-1 ends LOAD; in_last is not used for length.
- err_last pulses if in_last=1 on a beat with cnt<M1-1, or in_last=0 on beat M1-1. Frame processing continues regardless.
- L1: for each i in 0..N1-1, issue addresses j=0..M1-1 on consecutive cycles. acc = sat16(acc + (pix[j] ? w : 0)). Saturation detects signed overflow; positive overflow clamps to 0x7FFF, negative to 0x8000.
- L1 row writeback: after the last product of row i, h[i] = acc[15] ? 0 : acc (ReLU). acc then clears.
- L2: for each k in 0..N2-1 and i in 0..N1-1, p = signed(w)*signed(h[i]) at 32 bits. p is shifted right by FRAC with magnitude truncation toward zero, then clamped to [0x8000,0x7FFF]. acc = sat16(acc+p); o[k]=acc after the last product.
- ARGMAX: one class per cycle, with max initialised to 0 and label to 0. It updates only when o[k] > max (strict), so ties keep the lower index and all-nonpositive outputs give label 0.
- DONE: out_valid=1 and out_label is held stable until out_valid&out_ready, then the block goes to IDLE.
- w_addr holds its last value outside L1/L2. The ROM is read unconditionally (no enable).
- Reset, including mid-frame, aborts the frame with no partial label. Reset values: state IDLE, in_ready 0, out_valid 0, out_label 0, err_last 0, w_addr 0, accumulators/h/o 0.

## Timing
- 1-cycle ROM latency is pipelined: address j+1 is issued while data j accumulates. Each L1 row takes M1+1 cycles and each L2 row takes N1+1 cycles.
- Phase lengths: L1 is N1*(M1+1)=3250 cycles, L2 is N2*(N1+1)=110, ARGMAX is N2=10.
- out_valid rises N1*(M1+1)+N2*(N1+1)+N2+1 = 3371 clock edges after the edge that accepts pixel M1-1.
- in_ready deasserts on the edge after the final pixel is accepted. It reasserts 2 edges after the DONE handshake (DONE→IDLE→LOAD).
- out_ready held high in DONE: the handshake completes in the first DONE cycle, so out_valid is 1 for exactly one cycle.
- err_last is asserted in the cycle after the offending beat.

## Test plan
- All pixels 0, all weights 0 → out_label 0, out_valid after exactly 3371 cycles, err_last never pulses.
- Pixel 5 = 1, all others 0; w1[3][5]=0x0100; w2[7][3]=0x0100; others 0 → h[3]=0x0100, o[7]=0x0100, out_label 7.
- All pixels 1; w1 row 0 all 0x7FFF, row 1 all 0xFF00; w2[2][0]=0x0200 → h[0]=0x7FFF (saturated), h[1]=0 (ReLU), o[2]=0x7FFF, out_label 2.
- Weights chosen so o[1]=o[4]=0x0300 and the other outputs are lower → out_label 1. Separately, all o[k]<0 → out_label 0.
- out_ready low for 20 DONE cycles → out_valid and out_label stable and in_ready 0 throughout. Then release → a second frame is accepted with the correct label.
- in_last on pixel 100 → err_last pulse next cycle and the frame still completes. Separately, resetn low mid-L1 → all outputs at reset values, and the next full frame produces the correct label.

Source files
------------

// File: rtl/inference_sequencer.sv
// Time-multiplexed two-layer binary-input classifier. A single saturating MAC
// steps through layer 1 (with ReLU), layer 2 and argmax. It fetches weights from
// an external synchronous ROM that has one cycle of read latency.
module inference_sequencer #(
  parameter int unsigned M1    = 324,
  parameter int unsigned N1    = 10,
  parameter int unsigned N2    = 10,
  parameter int unsigned WIDTH = 16,
  parameter int unsigned FRAC  = 8,
  parameter int unsigned AW    = 12
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_pixel,
  input  logic             in_last,
  output logic [AW-1:0]    w_addr,
  input  logic [WIDTH-1:0] w_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_label,
  output logic             err_last
);

  localparam int unsigned CW = $clog2(M1 + 1);
  localparam int unsigned RW = 4;  // row/class index; N1, N2 <= 16
  localparam int unsigned PW = 2 * WIDTH;

  localparam logic signed [WIDTH-1:0] SMax = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] SMin = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [PW-1:0]    PMax = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [PW-1:0]    PMin = {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {StIdle, StLoad, StL1, StL2, StArgmax, StDone} state_e;

  // Signed add, clamped to the representable range on overflow
  function automatic logic signed [WIDTH-1:0] sat_add(input logic signed [WIDTH-1:0] a,
                                                      input logic signed [WIDTH-1:0] b);
    logic signed [WIDTH:0] s;
    s = {a[WIDTH-1], a} + {b[WIDTH-1], b};
    if (s[WIDTH] != s[WIDTH-1]) sat_add = s[WIDTH] ? SMin : SMax;
    else                        sat_add = s[WIDTH-1:0];
  endfunction

  // Drop FRAC bits rounding toward zero, then clamp to WIDTH bits
  function automatic logic signed [WIDTH-1:0] scale_prod(input logic signed [PW-1:0] p);
    logic [PW-1:0]        mag;
    logic signed [PW-1:0] q;
    mag = p[PW-1] ? PW'(-p) : PW'(p);
    mag = mag >> FRAC;
    q   = p[PW-1] ? -$signed(mag) : $signed(mag);
    if (q > PMax)      scale_prod = SMax;
    else if (q < PMin) scale_prod = SMin;
    else               scale_prod = q[WIDTH-1:0];
  endfunction

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d, col_q, col_d, colm1;
  logic [RW-1:0]           row_q, row_d;
  logic                    prime_q, prime_d;
  logic [M1-1:0]           pix_q, pix_d;
  logic signed [WIDTH-1:0] acc_q, acc_d, max_q, max_d;
  logic signed [WIDTH-1:0] h_q [N1];
  logic signed [WIDTH-1:0] h_d [N1];
  logic signed [WIDTH-1:0] o_q [N2];
  logic signed [WIDTH-1:0] o_d [N2];
  logic [3:0]              lbl_q, lbl_d, out_label_q, out_label_d;
  logic                    in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic                    err_last_q, err_last_d;
  logic [AW-1:0]           w_addr_q, w_addr_d;

  logic                    beat, last_beat, gt;
  logic signed [WIDTH-1:0] term_l1, acc_l1, acc_l2;
  logic signed [PW-1:0]    prod;

  // Next-state: FSM, counters, MAC datapath and registered outputs
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    col_d       = col_q;
    row_d       = row_q;
    prime_d     = prime_q;
    pix_d       = pix_q;
    acc_d       = acc_q;
    max_d       = max_q;
    h_d         = h_q;
    o_d         = o_q;
    lbl_d       = lbl_q;
    out_label_d = out_label_q;
    out_valid_d = out_valid_q;
    err_last_d  = 1'b0;
    w_addr_d    = w_addr_q;

    beat      = in_valid & in_ready_q;
    last_beat = (cnt_q == CW'(M1 - 1));
    colm1     = col_q - CW'(1);
    // ROM data arriving now belongs to the address issued last cycle (column col-1)
    term_l1   = pix_q[colm1] ? $signed(w_data) : '0;
    acc_l1    = sat_add(acc_q, term_l1);
    prod      = PW'($signed(w_data)) * PW'(h_q[colm1[RW-1:0]]);
    acc_l2    = sat_add(acc_q, scale_prod(prod));
    gt        = (o_q[row_q] > max_q);

    unique case (state_q)
      StIdle: begin
        cnt_d   = '0;
        col_d   = '0;
        row_d   = '0;
        acc_d   = '0;
        max_d   = '0;
        lbl_d   = '0;
        state_d = StLoad;
      end
      StLoad: begin
        if (beat) begin
          pix_d[cnt_q] = in_pixel;
          err_last_d   = (in_last != last_beat);
          if (last_beat) begin
            state_d = StL1;
            prime_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      StL1: begin
        if (prime_q) begin
          // Address only moves while in L1/L2, so the first fetch is issued here
          prime_d  = 1'b0;
          w_addr_d = '0;
        end else begin
          if (col_q != '0) acc_d = acc_l1;
          if (col_q == CW'(M1)) begin
            h_d[row_q] = acc_l1[WIDTH-1] ? '0 : acc_l1;
            acc_d      = '0;
            col_d      = '0;
            if (row_q == RW'(N1 - 1)) begin
              row_d   = '0;
              state_d = StL2;
            end else begin
              row_d = row_q + RW'(1);
            end
          end else begin
            // Rows are contiguous, so +1 also lands on the next row's first weight
            col_d    = col_q + CW'(1);
            w_addr_d = w_addr_q + AW'(1);
          end
        end
      end
      StL2: begin
        if (col_q != '0) acc_d = acc_l2;
        if (col_q == CW'(N1)) begin
          o_d[row_q] = acc_l2;
          acc_d      = '0;
          col_d      = '0;
          if (row_q == RW'(N2 - 1)) begin
            row_d   = '0;
            state_d = StArgmax;
          end else begin
            row_d = row_q + RW'(1);
          end
        end else begin
          col_d = col_q + CW'(1);
          if (!(row_q == RW'(N2 - 1) && col_q == CW'(N1 - 1))) w_addr_d = w_addr_q + AW'(1);
        end
      end
      StArgmax: begin
        // Strict compare: ties keep the lower class index
        if (gt) begin
          max_d = o_q[row_q];
          lbl_d = row_q;
        end
        if (row_q == RW'(N2 - 1)) begin
          out_label_d = gt ? row_q : lbl_q;
          out_valid_d = 1'b1;
          state_d     = StDone;
        end else begin
          row_d = row_q + RW'(1);
        end
      end
      StDone: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    in_ready_d = (state_d == StLoad);
  end

  // State and output registers; reset aborts any frame in flight
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      col_q       <= '0;
      row_q       <= '0;
      prime_q     <= 1'b0;
      pix_q       <= '0;
      acc_q       <= '0;
      max_q       <= '0;
      h_q         <= '{default: '0};
      o_q         <= '{default: '0};
      lbl_q       <= '0;
      out_label_q <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      err_last_q  <= 1'b0;
      w_addr_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      col_q       <= col_d;
      row_q       <= row_d;
      prime_q     <= prime_d;
      pix_q       <= pix_d;
      acc_q       <= acc_d;
      max_q       <= max_d;
      h_q         <= h_d;
      o_q         <= o_d;
      lbl_q       <= lbl_d;
      out_label_q <= out_label_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      err_last_q  <= err_last_d;
      w_addr_q    <= w_addr_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_label = out_label_q;
  assign err_last  = err_last_q;
  assign w_addr    = w_addr_q;

endmodule
